// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
// Shared Q2.29 constants and the FSM state encoding used by the iterative
// CORDIC sine/cosine controller.
// Q2.29: 1 sign bit, 2 integer bits and 29 fraction bits; 1.0 == 0x20000000.
// ----------------------------------------------------------------------------
package cordic_pkg;

   localparam int DATA_W = 32;

   localparam logic signed [DATA_W-1:0] PI            = 32'sh6487ED51;
   localparam logic signed [DATA_W-1:0] PI_BY_2       = 32'sh3243F6A9;
   localparam logic signed [DATA_W-1:0] MINUS_PI      = 32'sh9B7812AF;
   localparam logic signed [DATA_W-1:0] MINUS_PI_BY_2 = 32'shCDBC0957;
   localparam logic signed [DATA_W-1:0] CORDIC_K      = 32'sh136E9DB4;
   localparam logic signed [DATA_W-1:0] ONE           = 32'sh20000000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_CORRECT = 2'd2,
      ST_DONE    = 2'd3
   } cordic_state_e;

endpackage

// File: rtl/cordic_atan_lut.sv
// ----------------------------------------------------------------------------
// cordic_atan_lut
// Combinational table of atan(2^-idx) in Q2.29 for idx 0..28 (rounded).
// Ports:
//   idx  - in,  5 bits : micro-rotation index
//   atan - out, 32 bits: signed Q2.29 angle; 0 for idx > 28
// ----------------------------------------------------------------------------
module cordic_atan_lut
   import cordic_pkg::*;
(
   input  logic [4:0]               idx,
   output logic signed [DATA_W-1:0] atan
);

   always_comb begin
      atan = '0;
      case (idx)
         5'd0 : atan = 32'sh1921FB54;
         5'd1 : atan = 32'sh0ED63383;
         5'd2 : atan = 32'sh07D6DD7E;
         5'd3 : atan = 32'sh03FAB753;
         5'd4 : atan = 32'sh01FF55BC;
         5'd5 : atan = 32'sh00FFEAAE;
         5'd6 : atan = 32'sh007FFD55;
         5'd7 : atan = 32'sh003FFFAB;
         5'd8 : atan = 32'sh001FFFF5;
         5'd9 : atan = 32'sh000FFFFF;
         5'd10: atan = 32'sh00080000;
         5'd11: atan = 32'sh00040000;
         5'd12: atan = 32'sh00020000;
         5'd13: atan = 32'sh00010000;
         5'd14: atan = 32'sh00008000;
         5'd15: atan = 32'sh00004000;
         5'd16: atan = 32'sh00002000;
         5'd17: atan = 32'sh00001000;
         5'd18: atan = 32'sh00000800;
         5'd19: atan = 32'sh00000400;
         5'd20: atan = 32'sh00000200;
         5'd21: atan = 32'sh00000100;
         5'd22: atan = 32'sh00000080;
         5'd23: atan = 32'sh00000040;
         5'd24: atan = 32'sh00000020;
         5'd25: atan = 32'sh00000010;
         5'd26: atan = 32'sh00000008;
         5'd27: atan = 32'sh00000004;
         5'd28: atan = 32'sh00000002;
         default: atan = '0;
      endcase
   end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// ----------------------------------------------------------------------------
// cordic_iter_ctrl
// Iterative (one micro-rotation per clock) CORDIC sine/cosine engine with a
// valid/ready request port and a valid/ready result port. Latency from the
// accepting edge to out_valid is ITER+1 edges; one request in flight at a time.
//
// Parameters:
//   ITER      - micro-rotations per operation, 8..28
// Ports:
//   clk       - in : clock, rising edge
//   rst       - in : asynchronous active-high reset
//   angle_in  - in : signed Q2.29 reduced angle in [0, pi/2]
//   quad_in   - in : quadrant code; bit1 negates sine, bit0 negates cosine
//   in_valid  - in : request valid
//   in_ready  - out: request accepted this cycle (IDLE only)
//   sin_out   - out: signed Q2.29 sine
//   cos_out   - out: signed Q2.29 cosine
//   out_valid - out: result valid, held until out_ready
//   out_ready - in : consumer accepts the result
//
// Build option: define CORDIC_CTRL_SAT_EN to clamp results to [-1.0, +1.0].
// ----------------------------------------------------------------------------
module cordic_iter_ctrl
   import cordic_pkg::*;
#(
   parameter int ITER = 24
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        angle_in,
   input  logic [1:0]               quad_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] sin_out,
   output logic signed [DATA_W-1:0] cos_out,
   output logic                     out_valid,
   input  logic                     out_ready
);

   cordic_state_e state, state_nxt;

   logic signed [DATA_W-1:0] x, y, z;
   logic signed [DATA_W-1:0] atan_i;
   logic [4:0]               i;
   logic [1:0]               quad;
   logic                     last_iter;

   assign last_iter = (i == 5'(ITER - 1));

   // CORDIC gain may push a unit result a few LSB past 1.0; clamp when enabled.
   function automatic logic signed [DATA_W-1:0] sat_unit(input logic signed [DATA_W-1:0] v);
      logic signed [DATA_W-1:0] r;
      r = v;
`ifdef CORDIC_CTRL_SAT_EN
      if (v > ONE)
         r = ONE;
      else if (v < -ONE)
         r = -ONE;
`endif
      return r;
   endfunction

   cordic_atan_lut u_atan (
      .idx  (i),
      .atan (atan_i)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (last_iter)
               state_nxt = ST_CORRECT;
         end
         ST_CORRECT: state_nxt = ST_DONE;
         ST_DONE: begin
            if (out_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x         <= '0;
         y         <= '0;
         z         <= '0;
         i         <= '0;
         quad      <= '0;
         sin_out   <= '0;
         cos_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            // capture: start vector (K, 0) so no gain correction is needed later
            ST_IDLE: begin
               if (in_valid) begin
                  x    <= CORDIC_K;
                  y    <= '0;
                  z    <= angle_in;
                  quad <= quad_in;
                  i    <= '0;
               end
            end
            // one micro-rotation per cycle, all terms from pre-update values
            ST_RUN: begin
               if (!z[DATA_W-1]) begin
                  x <= x - (y >>> i);
                  y <= y + (x >>> i);
                  z <= z - atan_i;
               end else begin
                  x <= x + (y >>> i);
                  y <= y - (x >>> i);
                  z <= z + atan_i;
               end
               i <= i + 5'd1;
            end
            // quadrant sign correction into the result registers
            ST_CORRECT: begin
               sin_out   <= sat_unit(quad[1] ? -y : y);
               cos_out   <= sat_unit(quad[0] ? -x : x);
               out_valid <= 1'b1;
            end
            ST_DONE: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
`timescale 1ns/1ps
module tb_cordic_iter_ctrl;

   localparam int ITER = 24;
   localparam int LAT  = ITER + 1;
   localparam int TOL  = 512;

   logic               clk = 1'b0;
   logic               rst;
   logic [31:0]        angle_in;
   logic [1:0]         quad_in;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] sin_out;
   logic signed [31:0] cos_out;
   logic               out_valid;
   logic               out_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cordic_iter_ctrl #(.ITER(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .angle_in  (angle_in),
      .quad_in   (quad_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sin_out   (sin_out),
      .cos_out   (cos_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // ---------------- reference model: real trigonometry ----------------
   function automatic int to_q229(real v);
      real s;
      s = v * 536870912.0;
      if (s >= 0.0) return $rtoi(s + 0.5);
      else          return $rtoi(s - 0.5);
   endfunction

   function automatic real clamp1(real v);
`ifdef CORDIC_CTRL_SAT_EN
      if (v > 1.0)  return 1.0;
      if (v < -1.0) return -1.0;
`endif
      return v;
   endfunction

   function automatic real ang(logic [31:0] a);
      return $itor($signed(a)) / 536870912.0;
   endfunction

   function automatic int exp_sin(logic [31:0] a, logic [1:0] q);
      real s;
      s = $sin(ang(a));
      if (q[1]) s = -s;
      return to_q229(clamp1(s));
   endfunction

   function automatic int exp_cos(logic [31:0] a, logic [1:0] q);
      real c;
      c = $cos(ang(a));
      if (q[0]) c = -c;
      return to_q229(clamp1(c));
   endfunction

   // ---------------- stimulus drivers (called at #1 after an edge) ----------------
   task automatic start_op(input logic [31:0] a, input logic [1:0] q, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      angle_in = a; quad_in = q; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; angle_in = '0; quad_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || sin_out !== 32'sd0 || cos_out !== 32'sd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b sin=%h cos=%h want 0 0 0", out_valid, sin_out, cos_out);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_zero();
      int lat, d;
      start_op(32'h0, 2'b00, lat);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
      d = int'(sin_out);
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL zero_sin: got %h want ~0", sin_out); end
      d = int'(cos_out) - 32'h20000000;
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL zero_cos: got %h want ~20000000", cos_out); end
      finish_op();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_handshake: got valid=%b ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_pi_by_2();
      int lat, d;
      start_op(32'h3243F6A9, 2'b00, lat);
      d = int'(sin_out) - 32'h20000000;
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL pi2_sin: got %h want ~20000000", sin_out); end
      d = int'(cos_out);
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL pi2_cos: got %h want ~0", cos_out); end
      finish_op();
   endtask

   task automatic test_pi_by_6();
      int lat, d;
      start_op(32'h10C15238, 2'b01, lat);
      d = int'(sin_out) - 32'sh10000000;
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL pi6_q01_sin: got %h want ~10000000", sin_out); end
      d = int'(cos_out) + 32'sh1BB67AE8;
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL pi6_q01_cos: got %h want ~-1BB67AE8", cos_out); end
      finish_op();
      start_op(32'h10C15238, 2'b11, lat);
      d = int'(sin_out) + 32'sh10000000;
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL pi6_q11_sin: got %h want ~-10000000", sin_out); end
      d = int'(cos_out) + 32'sh1BB67AE8;
      checks++;
      if (d > TOL || d < -TOL) begin errors++; $display("FAIL pi6_q11_cos: got %h want ~-1BB67AE8", cos_out); end
      finish_op();
   endtask

   task automatic test_back_to_back();
      int lat, d;
      logic [31:0] a;
      logic [1:0]  q;
      logic signed [31:0] s_keep;
      for (int n = 0; n < 20; n++) begin
         a = $urandom_range(0, 32'h3243F6A9);
         q = 2'($urandom_range(0, 3));
         start_op(a, q, lat);
         checks++;
         if (lat !== LAT) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", n, lat, LAT); end
         d = int'(sin_out) - exp_sin(a, q);
         checks++;
         if (d > TOL || d < -TOL) begin
            errors++;
            $display("FAIL b2b_sin[%0d]: angle=%h quad=%b got %h want ~%h", n, a, q, sin_out, exp_sin(a, q));
         end
         d = int'(cos_out) - exp_cos(a, q);
         checks++;
         if (d > TOL || d < -TOL) begin
            errors++;
            $display("FAIL b2b_cos[%0d]: angle=%h quad=%b got %h want ~%h", n, a, q, cos_out, exp_cos(a, q));
         end
         s_keep = sin_out;
         finish_op();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || sin_out !== s_keep) begin
            errors++;
            $display("FAIL b2b_after_handshake[%0d]: got ready=%b valid=%b sin=%h want 1 0 %h",
                     n, in_ready, out_valid, sin_out, s_keep);
         end
      end
   endtask

   task automatic test_hold();
      int lat;
      int seen;
      logic signed [31:0] s, c;
      start_op($urandom_range(32'h04000000, 32'h2E000000), 2'b10, lat);
      s = sin_out; c = cos_out;
      for (int n = 0; n < 10; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         angle_in = $urandom;
         quad_in  = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sin_out !== s || cos_out !== c) begin
            errors++;
            $display("FAIL hold[%0d]: got valid=%b ready=%b sin=%h cos=%h want 1 0 %h %h",
                     n, out_valid, in_ready, sin_out, cos_out, s, c);
         end
      end
      in_valid = 1'b0;
      finish_op();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sin_out !== s || cos_out !== c) begin
         errors++;
         $display("FAIL hold_release: got valid=%b ready=%b sin=%h cos=%h want 0 1 %h %h",
                  out_valid, in_ready, sin_out, cos_out, s, c);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL hold_no_queue: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_reset_mid();
      int lat, seen, d;
      logic [31:0] a;
      while (!in_ready) begin @(posedge clk); #1; end
      angle_in = 32'h1A000000; quad_in = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sin_out !== 32'sd0 || cos_out !== 32'sd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_async: got valid=%b sin=%h cos=%h ready=%b want 0 0 0 1",
                  out_valid, sin_out, cos_out, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL midreset_no_result: got %0d valid cycles want 0", seen); end
      a = $urandom_range(0, 32'h3243F6A9);
      start_op(a, 2'b01, lat);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL midreset_next_latency: got %0d want %0d", lat, LAT); end
      d = int'(cos_out) - exp_cos(a, 2'b01);
      checks++;
      if (d > TOL || d < -TOL) begin
         errors++;
         $display("FAIL midreset_next_cos: got %h want ~%h", cos_out, exp_cos(a, 2'b01));
      end
      finish_op();
   endtask

   task automatic test_out_of_range();
      int lat;
      start_op(32'h7FFFFFFF, 2'($urandom_range(0, 3)), lat);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL oor_latency: got %0d want %0d", lat, LAT); end
      finish_op();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL oor_return_idle: got %b want 1", in_ready); end
   endtask

`ifdef CORDIC_CTRL_SAT_EN
   task automatic test_sat();
      int lat, d;
      start_op(32'h0, 2'b00, lat);
      d = int'(cos_out);
      checks++;
      if (d > 32'sh20000000 || d < 32'sh20000000 - TOL) begin
         errors++;
         $display("FAIL sat_cos: got %h want <=20000000 and near it", cos_out);
      end
      finish_op();
   endtask
`endif

   initial begin
      test_reset();
      test_zero();
      test_pi_by_2();
      test_pi_by_6();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      test_out_of_range();
`ifdef CORDIC_CTRL_SAT_EN
      test_sat();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 SHALL have parameter ITER, default 24, meaning the number of CORDIC micro-rotations per operation, legal range 8..28.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port angle_in, input, 32 bits: signed Q2.29 reduced angle in [0, pi/2].
REQ-005 SHALL have port quad_in, input, 2 bits: quadrant code accompanying angle_in.
REQ-006 SHALL have port in_valid, input, 1 bit: angle_in and quad_in are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 SHALL have port sin_out, output, 32 bits: signed Q2.29 sine result.
REQ-009 SHALL have port cos_out, output, 32 bits: signed Q2.29 cosine result.
REQ-010 SHALL have port out_valid, output, 1 bit: sin_out and cos_out hold a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN, CORRECT and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL accept a request when in_valid&in_ready, capturing x=K (0x136E9DB4), y=0, z=angle_in, quad=quad_in and iteration counter i=0, then go to RUN.
REQ-015 SHALL, on each RUN cycle, set d=+1 if z>=0 else -1 and update x-=d*(y>>>i), y+=d*(x>>>i), z-=d*atan(2^-i), all using the pre-update values, arithmetic shifts and 32-bit two's-complement wrap, then increment i.
REQ-016 SHALL leave RUN for CORRECT after exactly ITER iterations (i==ITER-1).
REQ-017 SHALL, in CORRECT, register sin_out=quad[1]?-y:y and cos_out=quad[0]?-x:x, set out_valid=1 and go to DONE.
REQ-018 SHALL assert out_valid at the ITER+1th rising edge after the accepting edge (latency ITER+1).
REQ-019 SHALL, in DONE, hold sin_out, cos_out and out_valid stable until out_ready=1, then clear out_valid and go to IDLE; one bubble cycle minimum between operations.
REQ-020 SHALL ignore in_valid outside IDLE and SHALL NOT queue requests.
REQ-021 SHALL complete an angle_in outside [0, pi/2] in the same ITER+1 cycles, with the result values unspecified.
REQ-022 SHALL retain sin_out and cos_out from the last result after the DONE handshake.

Reset
REQ-023 SHALL, on rst, immediately set state=IDLE, out_valid=0, sin_out=0, cos_out=0, i=0, x=y=z=0 and quad=0, regardless of state.
REQ-024 SHALL discard any reset mid-RUN/CORRECT/DONE operation and SHALL NOT produce a result for it.
REQ-025 SHALL make in_ready=1 on the first edge after rst deasserts.

Configuration
REQ-026 SHALL, when CORDIC_CTRL_SAT_EN is defined, clamp the corrected sin/cos in CORRECT to [-1.0, +1.0], i.e. [0xE0000000, 0x20000000].
REQ-027 SHALL, without CORDIC_CTRL_SAT_EN, pass the corrected values unclamped; latency is identical either way.

Structure
REQ-028 SHALL take from shared package cordic_pkg the Q2.29 constants PI, PI_BY_2, MINUS_PI, MINUS_PI_BY_2, CORDIC_K and ONE, plus the FSM state encoding.
REQ-029 SHALL take atan(2^-i) from sub-module cordic_atan_lut, a combinational 29-entry Q2.29 table indexed 0..28.

Verification
REQ-030 SHALL be verified for angle 0x00000000, quad 00 -> sin within ±512 LSB of 0 and cos within ±512 LSB of 0x20000000, out_valid after 25 edges (ITER=24).
REQ-031 SHALL be verified for angle 0x3243F6A9 (pi/2), quad 00 -> sin≈0x20000000 and cos≈0, within ±512 LSB.
REQ-032 SHALL be verified for angle pi/6 (0x10C15238), quad 01 -> sin≈+0x10000000 and cos≈-0x1BB67AE8; quad 11 -> both negated.
REQ-033 SHALL be verified by holding out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 and in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-034 SHALL be verified by asserting rst at RUN iteration 5 -> out_valid=0 and outputs 0 immediately, in_ready=1 after release, next request correct.
REQ-035 SHALL be verified with CORDIC_CTRL_SAT_EN defined, angle 0, quad 00 -> cos_out<=0x20000000 exactly.
